// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;

    // Requester identity; also the encoding of the round-robin pointer.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO of {dest reg, data} writeback entries.
// Exposes per-entry valid/dest so the parent can build a pending mask.
module wb_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [ADDR_W-1:0]            push_reg_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [ADDR_W-1:0]            head_reg_o,
    output logic [DATA_W-1:0]            head_data_o,
    output logic [DEPTH-1:0]             ent_valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_reg_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][ADDR_W-1:0] reg_q, reg_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

    logic do_push, do_pop;

    // Per-slot valid bits make full/empty direct reductions, no counter needed.
    assign full_o      = &vld_q;
    assign empty_o     = ~|vld_q;
    assign do_push     = push_i & ~full_o;
    assign do_pop      = pop_i & ~empty_o;
    assign head_reg_o  = reg_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign ent_valid_o = vld_q;
    assign ent_reg_o   = reg_q;

    // Next-state: write at wr_ptr, retire at rd_ptr; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        reg_d    = reg_q;
        data_d   = data_q;
        if (do_push) begin
            reg_d[wr_ptr_q]  = push_reg_i;
            data_d[wr_ptr_q] = push_data_i;
            vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
    end

    // State register with asynchronous clear of all entries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
            reg_q    <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// ALU and load writeback paths. Port outputs are registered on posedge so
// the register file can sample them on negedge.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_reg,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 RegWrite,
    output logic [ADDR_W-1:0]    writeReg,
    output logic [DATA_W-1:0]    writeData,
    output logic [2**ADDR_W-1:0] pending,
    output logic                 idle
);

    logic                         alu_full, alu_empty, mem_full, mem_empty;
    logic [ADDR_W-1:0]            alu_head_reg, mem_head_reg;
    logic [DATA_W-1:0]            alu_head_data, mem_head_data;
    logic [DEPTH-1:0]             alu_ent_vld, mem_ent_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] alu_ent_reg, mem_ent_reg;
    logic                         alu_push, mem_push, grant_alu, grant_mem;

    req_e              rr_q, rr_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Writes to r0 complete the handshake but are never stored.
    assign alu_ready = ~reset & ~alu_full;
    assign mem_ready = ~reset & ~mem_full;
    assign alu_push  = alu_valid & alu_ready & (alu_reg != ADDR_W'(REG_ZERO));
    assign mem_push  = mem_valid & mem_ready & (mem_reg != ADDR_W'(REG_ZERO));

    wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_alu_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (alu_push),
        .push_reg_i  (alu_reg),
        .push_data_i (alu_data),
        .pop_i       (grant_alu),
        .full_o      (alu_full),
        .empty_o     (alu_empty),
        .head_reg_o  (alu_head_reg),
        .head_data_o (alu_head_data),
        .ent_valid_o (alu_ent_vld),
        .ent_reg_o   (alu_ent_reg)
    );

    wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (mem_push),
        .push_reg_i  (mem_reg),
        .push_data_i (mem_data),
        .pop_i       (grant_mem),
        .full_o      (mem_full),
        .empty_o     (mem_empty),
        .head_reg_o  (mem_head_reg),
        .head_data_o (mem_head_data),
        .ent_valid_o (mem_ent_vld),
        .ent_reg_o   (mem_ent_reg)
    );

    // Grant selection: lone non-empty side wins, ties go to rr; rr flips after a grant.
    always_comb begin
        grant_alu  = 1'b0;
        grant_mem  = 1'b0;
        rr_d       = rr_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (!alu_empty && (mem_empty || rr_q == REQ_ALU)) begin
            grant_alu  = 1'b1;
            rr_d       = REQ_MEM;
            regwrite_d = 1'b1;
            wreg_d     = alu_head_reg;
            wdata_d    = alu_head_data;
        end else if (!mem_empty) begin
            grant_mem  = 1'b1;
            rr_d       = REQ_ALU;
            regwrite_d = 1'b1;
            wreg_d     = mem_head_reg;
            wdata_d    = mem_head_data;
        end
    end

    // Registered write port and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q       <= REQ_ALU;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            rr_q       <= rr_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Pending mask: every buffered destination plus the one on the port now.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_ent_vld[i]) pending[alu_ent_reg[i]] = 1'b1;
            if (mem_ent_vld[i]) pending[mem_ent_reg[i]] = 1'b1;
        end
        if (regwrite_q) pending[wreg_q] = 1'b1;
    end

    assign RegWrite  = regwrite_q;
    assign writeReg  = wreg_q;
    assign writeData = wdata_q;
    assign idle      = alu_empty & mem_empty & ~regwrite_q;

endmodule
